// File: rtl/reg_file_ctl_pkg.sv
// Shared types and physical select layout for the register file controller.
package reg_file_pkg;

  typedef enum logic [3:0] {
    RC_BC = 4'd0,
    RC_DE = 4'd1,
    RC_HL = 4'd2,
    RC_AF = 4'd3,
    RC_IX = 4'd4,
    RC_IY = 4'd5,
    RC_SP = 4'd6,
    RC_WZ = 4'd7,
    RC_PC = 4'd8,
    RC_IR = 4'd9
  } reg_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NUM_SEL = 14;

  localparam logic [3:0] SEL_AF  = 4'd0;
  localparam logic [3:0] SEL_AF2 = 4'd1;
  localparam logic [3:0] SEL_BC  = 4'd2;
  localparam logic [3:0] SEL_BC2 = 4'd3;
  localparam logic [3:0] SEL_DE  = 4'd4;
  localparam logic [3:0] SEL_DE2 = 4'd5;
  localparam logic [3:0] SEL_HL  = 4'd6;
  localparam logic [3:0] SEL_HL2 = 4'd7;
  localparam logic [3:0] SEL_IX  = 4'd8;
  localparam logic [3:0] SEL_IY  = 4'd9;
  localparam logic [3:0] SEL_WZ  = 4'd10;
  localparam logic [3:0] SEL_SP  = 4'd11;
  localparam logic [3:0] SEL_PC  = 4'd12;
  localparam logic [3:0] SEL_IR  = 4'd13;

  function automatic logic is_sys(input logic [NUM_SEL-1:0] sel);
    return sel[SEL_PC] | sel[SEL_IR];
  endfunction

  // An all-zero select (illegal code) is neither GP nor system.
  function automatic logic is_gp(input logic [NUM_SEL-1:0] sel);
    return (|sel) & ~is_sys(sel);
  endfunction

endpackage

// File: rtl/reg_file_ctl_if.sv
// Requester, exchange-command and register-file control signals of the controller.
interface reg_file_ctl_if;
  logic       a_req, a_we, a_hi, a_lo, a_done;
  logic [3:0] a_reg;
  logic       b_req, b_we, b_hi, b_lo, b_done;
  logic [3:0] b_reg;
  logic       ex_af, exx, ex_dehl;
  logic       reg_sel_af, reg_sel_af2, reg_sel_bc, reg_sel_bc2;
  logic       reg_sel_de, reg_sel_de2, reg_sel_hl, reg_sel_hl2;
  logic       reg_sel_ix, reg_sel_iy, reg_sel_wz, reg_sel_sp;
  logic       reg_sel_pc, reg_sel_ir;
  logic       reg_sel_gp_hi, reg_sel_gp_lo, reg_gp_oe;
  logic       reg_sel_sys_hi, reg_sel_sys_lo, reg_sys_oe;
  logic       reg_we, busy;

  modport master (
    output a_req, a_we, a_reg, a_hi, a_lo,
    output b_req, b_we, b_reg, b_hi, b_lo,
    output ex_af, exx, ex_dehl,
    input  a_done, b_done,
    input  reg_sel_af, reg_sel_af2, reg_sel_bc, reg_sel_bc2,
    input  reg_sel_de, reg_sel_de2, reg_sel_hl, reg_sel_hl2,
    input  reg_sel_ix, reg_sel_iy, reg_sel_wz, reg_sel_sp,
    input  reg_sel_pc, reg_sel_ir,
    input  reg_sel_gp_hi, reg_sel_gp_lo, reg_gp_oe,
    input  reg_sel_sys_hi, reg_sel_sys_lo, reg_sys_oe,
    input  reg_we, busy
  );

  modport slave (
    input  a_req, a_we, a_reg, a_hi, a_lo,
    input  b_req, b_we, b_reg, b_hi, b_lo,
    input  ex_af, exx, ex_dehl,
    output a_done, b_done,
    output reg_sel_af, reg_sel_af2, reg_sel_bc, reg_sel_bc2,
    output reg_sel_de, reg_sel_de2, reg_sel_hl, reg_sel_hl2,
    output reg_sel_ix, reg_sel_iy, reg_sel_wz, reg_sel_sp,
    output reg_sel_pc, reg_sel_ir,
    output reg_sel_gp_hi, reg_sel_gp_lo, reg_gp_oe,
    output reg_sel_sys_hi, reg_sel_sys_lo, reg_sys_oe,
    output reg_we, busy
  );
endinterface

// File: rtl/reg_file_ctl_bank_map.sv
// Combinational remap of a logical register code plus bank state to a one-hot physical select.
module reg_bank_map
  import reg_file_pkg::*;
(
  input  logic [3:0]         i_code,
  input  logic               i_af_bank,
  input  logic               i_exx_bank,
  input  logic               i_swap0,
  input  logic               i_swap1,
  output logic [NUM_SEL-1:0] o_sel
);

  logic [3:0] w_idx;
  logic       w_valid;
  logic       w_swap;

  // DE/HL swap flag belongs to whichever bank is currently active.
  assign w_swap = i_exx_bank ? i_swap1 : i_swap0;

  always_comb begin
    w_idx   = SEL_AF;
    w_valid = 1'b1;
    case (reg_code_t'(i_code))
      RC_BC: w_idx = i_exx_bank ? SEL_BC2 : SEL_BC;
      RC_DE: w_idx = w_swap ? (i_exx_bank ? SEL_HL2 : SEL_HL)
                            : (i_exx_bank ? SEL_DE2 : SEL_DE);
      RC_HL: w_idx = w_swap ? (i_exx_bank ? SEL_DE2 : SEL_DE)
                            : (i_exx_bank ? SEL_HL2 : SEL_HL);
      RC_AF: w_idx = i_af_bank ? SEL_AF2 : SEL_AF;
      RC_IX: w_idx = SEL_IX;
      RC_IY: w_idx = SEL_IY;
      RC_SP: w_idx = SEL_SP;
      RC_WZ: w_idx = SEL_WZ;
      RC_PC: w_idx = SEL_PC;
      RC_IR: w_idx = SEL_IR;
      default: w_valid = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEL; gi++) begin : g_sel
      assign o_sel[gi] = w_valid && (w_idx == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/reg_file_ctl.sv
// Two-requester round-robin sequencer for the register file, with bank-exchange state.
module reg_file_ctl
  import reg_file_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic          clk,
  input  logic          nreset,
  reg_file_ctl_if.slave bus
);

  state_t               r_state;
  logic                 r_last_b;
  logic                 r_grant_b;
  logic                 r_we_l;
  logic                 r_af_bank, r_exx_bank, r_swap0, r_swap1;
  logic                 r_pend_af, r_pend_exx, r_pend_dehl;
  logic [NUM_SEL-1:0]   r_sel;
  logic                 r_gp_hi, r_gp_lo, r_gp_oe;
  logic                 r_sys_hi, r_sys_lo, r_sys_oe;
  logic                 r_reg_we, r_busy, r_a_done, r_b_done;

  logic [NUM_REQ-1:0]   w_req;
  logic                 w_pick_b;
  logic [3:0]           w_code;
  logic                 w_we, w_hi, w_lo;
  logic [NUM_SEL-1:0]   w_map_sel;
  logic                 w_apply;
  logic                 w_t_af, w_t_exx, w_t_dehl, w_exx_new;

  assign w_req    = {bus.b_req, bus.a_req};
  // On contention the requester that did not win last time takes the grant.
  assign w_pick_b = w_req[1] & (~w_req[0] | ~r_last_b);
  assign w_code   = w_pick_b ? bus.b_reg : bus.a_reg;
  assign w_we     = w_pick_b ? bus.b_we  : bus.a_we;
  assign w_hi     = w_pick_b ? bus.b_hi  : bus.a_hi;
  assign w_lo     = w_pick_b ? bus.b_lo  : bus.a_lo;

  reg_bank_map u_map (
    .i_code     (w_code),
    .i_af_bank  (r_af_bank),
    .i_exx_bank (r_exx_bank),
    .i_swap0    (r_swap0),
    .i_swap1    (r_swap1),
    .o_sel      (w_map_sel)
  );

  // Exchanges only land while idle or on the DONE->IDLE edge, so a granted transaction never sees a remap.
  assign w_apply   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_t_af    = bus.ex_af   ^ r_pend_af;
  assign w_t_exx   = bus.exx     ^ r_pend_exx;
  assign w_t_dehl  = bus.ex_dehl ^ r_pend_dehl;
  assign w_exx_new = r_exx_bank ^ w_t_exx;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= ST_IDLE;
      r_last_b    <= 1'b1;
      r_grant_b   <= 1'b0;
      r_we_l      <= 1'b0;
      r_af_bank   <= 1'b0;
      r_exx_bank  <= 1'b0;
      r_swap0     <= 1'b0;
      r_swap1     <= 1'b0;
      r_pend_af   <= 1'b0;
      r_pend_exx  <= 1'b0;
      r_pend_dehl <= 1'b0;
      r_sel       <= '0;
      r_gp_hi     <= 1'b0;
      r_gp_lo     <= 1'b0;
      r_gp_oe     <= 1'b0;
      r_sys_hi    <= 1'b0;
      r_sys_lo    <= 1'b0;
      r_sys_oe    <= 1'b0;
      r_reg_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_a_done    <= 1'b0;
      r_b_done    <= 1'b0;
    end else begin
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_state   <= ST_SETUP;
            r_busy    <= 1'b1;
            r_grant_b <= w_pick_b;
            r_last_b  <= w_pick_b;
            r_we_l    <= w_we;
            r_sel     <= w_map_sel;
            r_gp_hi   <= w_hi & is_gp(w_map_sel);
            r_gp_lo   <= w_lo & is_gp(w_map_sel);
            r_sys_hi  <= w_hi & is_sys(w_map_sel);
            r_sys_lo  <= w_lo & is_sys(w_map_sel);
          end
        end
        ST_SETUP: begin
          r_state  <= ST_ACTIVE;
          r_reg_we <= r_we_l & (|r_sel);
          r_gp_oe  <= ~r_we_l & is_gp(r_sel);
          r_sys_oe <= ~r_we_l & is_sys(r_sel);
        end
        ST_ACTIVE: begin
          r_state  <= ST_DONE;
          r_sel    <= '0;
          r_gp_hi  <= 1'b0;
          r_gp_lo  <= 1'b0;
          r_gp_oe  <= 1'b0;
          r_sys_hi <= 1'b0;
          r_sys_lo <= 1'b0;
          r_sys_oe <= 1'b0;
          r_reg_we <= 1'b0;
          r_a_done <= ~r_grant_b;
          r_b_done <= r_grant_b;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_apply) begin
        r_af_bank   <= r_af_bank ^ w_t_af;
        r_exx_bank  <= w_exx_new;
        // ex_dehl acts on the bank that is active after any simultaneous exx.
        r_swap0     <= r_swap0 ^ (w_t_dehl & ~w_exx_new);
        r_swap1     <= r_swap1 ^ (w_t_dehl & w_exx_new);
        r_pend_af   <= 1'b0;
        r_pend_exx  <= 1'b0;
        r_pend_dehl <= 1'b0;
      end else begin
        r_pend_af   <= r_pend_af   ^ bus.ex_af;
        r_pend_exx  <= r_pend_exx  ^ bus.exx;
        r_pend_dehl <= r_pend_dehl ^ bus.ex_dehl;
      end
    end
  end

  assign bus.reg_sel_af     = r_sel[SEL_AF];
  assign bus.reg_sel_af2    = r_sel[SEL_AF2];
  assign bus.reg_sel_bc     = r_sel[SEL_BC];
  assign bus.reg_sel_bc2    = r_sel[SEL_BC2];
  assign bus.reg_sel_de     = r_sel[SEL_DE];
  assign bus.reg_sel_de2    = r_sel[SEL_DE2];
  assign bus.reg_sel_hl     = r_sel[SEL_HL];
  assign bus.reg_sel_hl2    = r_sel[SEL_HL2];
  assign bus.reg_sel_ix     = r_sel[SEL_IX];
  assign bus.reg_sel_iy     = r_sel[SEL_IY];
  assign bus.reg_sel_wz     = r_sel[SEL_WZ];
  assign bus.reg_sel_sp     = r_sel[SEL_SP];
  assign bus.reg_sel_pc     = r_sel[SEL_PC];
  assign bus.reg_sel_ir     = r_sel[SEL_IR];
  assign bus.reg_sel_gp_hi  = r_gp_hi;
  assign bus.reg_sel_gp_lo  = r_gp_lo;
  assign bus.reg_gp_oe      = r_gp_oe;
  assign bus.reg_sel_sys_hi = r_sys_hi;
  assign bus.reg_sel_sys_lo = r_sys_lo;
  assign bus.reg_sys_oe     = r_sys_oe;
  assign bus.reg_we         = r_reg_we;
  assign bus.busy           = r_busy;
  assign bus.a_done         = r_a_done;
  assign bus.b_done         = r_b_done;

endmodule

// File: doc/reg_file_ctl.md
# reg_file_ctl

Sequencer and arbiter for the CPU register file. It accepts 16-bit register access requests from two requesters: the execution sequencer (port A) and the interrupt/refresh unit (port B). It arbitrates between them and drives the register file select, byte-enable, write and output-enable lines as a two-phase transaction. It also holds the register-bank exchange state (EX AF,AF' / EXX / EX DE,HL) and remaps logical register codes onto physical register selects.

## Interface
- `NUM_REQ`, default 2: number of requesters; only 2 is supported.
- `clk`  in  1  CPU clock.
- `nreset`  in  1  asynchronous, active-low reset.
- `a_req` / `b_req`  in  1  request valid; held until the matching done pulse.
- `a_we` / `b_we`  in  1  1 = write (register file samples data buses), 0 = read (register drives data buses).
- `a_reg` / `b_reg`  in  4  logical register code (`reg_code_t`).
- `a_hi`, `a_lo` / `b_hi`, `b_lo`  in  1  byte enables.
- `a_done` / `b_done`  out  1  one-cycle completion pulse.
- `ex_af`, `exx`, `ex_dehl`  in  1  exchange commands, one-cycle pulses.
- `reg_sel_af`, `reg_sel_af2`, `reg_sel_bc`, `reg_sel_bc2`, `reg_sel_de`, `reg_sel_de2`, `reg_sel_hl`, `reg_sel_hl2`, `reg_sel_ix`, `reg_sel_iy`, `reg_sel_wz`, `reg_sel_sp`, `reg_sel_pc`, `reg_sel_ir`  out  1 each  physical selects; at most one is high.
- `reg_sel_gp_hi`, `reg_sel_gp_lo`, `reg_gp_oe`  out  1  GP byte selects and output enable.
- `reg_sel_sys_hi`, `reg_sel_sys_lo`, `reg_sys_oe`  out  1  system (PC/IR) byte selects and output enable.
- `reg_we`  out  1  write strobe.
- `busy`  out  1  transaction in progress.

## Operation
- Register codes: BC=0, DE=1, HL=2, AF=3, IX=4, IY=5, SP=6, WZ=7, PC=8, IR=9.
  - Codes 10-15 are illegal. The request completes with `done` and asserts no select, strobe or output enable.
- Bank state registers: `af_bank`, `exx_bank`, `dehl_swap0`, `dehl_swap1`. All reset to 0.
- Remap rules:
  - AF maps to AF2 when `af_bank`=1.
  - BC/DE/HL map to BC2/DE2/HL2 when `exx_bank`=1.
  - DE and HL are swapped when the swap flag of the active bank is 1.
- Exchange commands:
  - `ex_af` toggles `af_bank`.
  - `exx` toggles `exx_bank`.
  - `ex_dehl` toggles the swap flag of the currently active bank.
- Exchange timing:
  - When IDLE, the exchange applies on the next edge.
  - When not IDLE, the command is latched as pending and applied on the cycle the FSM returns to IDLE, so remapping never changes mid-transaction.
  - `exx` and `ex_dehl` arriving together: `exx` applies first, then `ex_dehl` toggles the new bank's swap flag.
  - A second pulse of the same command while pending cancels the pending toggle (net effect is even).
- FSM states:
  - IDLE: grant on any request and go to SETUP.
  - SETUP: select and byte selects asserted; `reg_we`/oe low.
  - ACTIVE: select, byte selects, and `reg_we` (write) or `reg_gp_oe`/`reg_sys_oe` (read) asserted.
  - DONE: all outputs low, `done` pulse to the granted requester; go to IDLE.
- Arbitration is round-robin. The `last_grant` bit resets to B, so A wins the first contention. A request is sampled only in IDLE.
- GP registers use the `gp_*` lines; PC/IR use the `sys_*` lines. A code with both byte enables low still runs the full FSM with no byte selects.
- All control outputs are registered and decoded from state plus the latched request.

## Timing
- Reset: all outputs 0, state IDLE, bank state 0, pending exchanges cleared, `last_grant`=B.
- Reset mid-transaction: outputs drop asynchronously. No `done` is issued and the requester must re-request.
- Latency: request seen in IDLE at edge N gives SETUP at N+1, ACTIVE at N+2, and `done` high during N+3.
- Back-to-back: the minimum period per transaction is 4 cycles, because IDLE is always visited.
- `busy` = state != IDLE.
- The requester holds `req`, `reg`, `we` and the byte enables stable until `done`. The block latches them at grant, so later changes are ignored.
- Dropping `req` before grant withdraws the request. Dropping it after grant has no effect.

## Structure
- Package `reg_file_pkg`: `reg_code_t` enum, `state_t` enum, and the physical select index constants.
- Sub-module `reg_bank_map`: a combinational remap of code plus bank state to a one-hot 14-bit physical select. It is reused by the bank-state unit test.
- The arbiter, FSM and bank-state flops live in `reg_file_ctl`.

## Test plan
- A-only write of AF (hi=lo=1) from reset:
  - `reg_sel_af` and both gp byte selects go high at N+1.
  - `reg_we` goes high at N+2 only.
  - `a_done` pulses at N+3.
- `ex_af` in IDLE, then an A read of AF: `reg_sel_af2` and `reg_gp_oe` are high in ACTIVE, and `reg_sel_af` stays low.
- `exx` then `ex_dehl`, then read DE: `reg_sel_hl2` is asserted. After a further `exx`, reading DE asserts `reg_sel_de`.
- A and B both request PC reads in the same cycle:
  - A is granted first and asserts `reg_sel_pc` plus `reg_sys_oe`.
  - B is granted on the next IDLE.
  - `a_done` and `b_done` are exactly 4 cycles apart.
- `exx` pulsed during ACTIVE of an HL write: the write selects `reg_sel_hl`, and the bank toggles only on return to IDLE.
- `nreset` low during ACTIVE:
  - All selects, `reg_we` and `busy` go to 0 immediately.
  - No `done` is issued.
  - Bank state returns to 0.
